load_store_unit: RTL and testbench

- Data-memory access stage for the RISC-V core, directly upstream of the writeback result selector.
- Takes the ALU-computed address, store data and funct3 from the execute path.
- Runs one transaction on a valid/ready data bus, stalling the core until the access completes.
- Delivers the lane-extracted, sign/zero-extended load word on readdata for writeback.

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory access stage: checks a load/store, runs one valid/ready bus transaction
// and delivers the lane-extracted, sign/zero-extended load word for writeback.
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int TOW     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t         state, next_state;
  logic [TOW-1:0] count;
  logic [2:0]     lat_f3;
  logic [1:0]     lat_off;
  logic           lat_load;
  logic           access, bad_req, timeout_hit;
  logic [3:0]     wstrb_c;
  logic [31:0]    wdata_c, load_data;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;

  assign access      = memread | memwrite;
  assign timeout_hit = (count == TOW'(TIMEOUT - 1));

  // Illegal combinations and misalignment are rejected before any bus activity.
  always_comb begin
    bad_req = 1'b0;
    if (memread && memwrite)
      bad_req = 1'b1;
    else if (memwrite && !(funct3 inside {3'b000, 3'b001, 3'b010}))
      bad_req = 1'b1;
    else if (memread && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
      bad_req = 1'b1;
    else if (funct3[1:0] == 2'b01 && addr[0])
      bad_req = 1'b1;
    else if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
      bad_req = 1'b1;
  end

  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = writedata;
    case (funct3[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << addr[1:0];
        wdata_c = {4{writedata[7:0]}};
      end
      2'b01: begin
        wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{writedata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b    = bus_rdata[{lat_off, 3'b000} +: 8];
    lane_h    = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_data = bus_rdata;
    case (lat_f3)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'b0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'b0, lane_h};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (access) next_state = bad_req ? DONE : REQ;
      REQ:     if (bus_ready || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Reset forces stall low even if the core still presents an access.
  always_comb begin
    stall = rst_n & (((state == IDLE) & access) | (state == REQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata  <= '0;
      fault     <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      count     <= '0;
      lat_f3    <= '0;
      lat_off   <= '0;
      lat_load  <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (bad_req) begin
              fault <= 1'b1;
              if (memread) readdata <= '0;
            end else begin
              bus_valid <= 1'b1;
              bus_we    <= memwrite;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= memwrite ? wstrb_c : 4'b0000;
              bus_wdata <= wdata_c;
              lat_f3    <= funct3;
              lat_off   <= addr[1:0];
              lat_load  <= memread;
              count     <= '0;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (bus_err) begin
              fault <= 1'b1;
              if (lat_load) readdata <= '0;
            end else if (lat_load) begin
              readdata <= load_data;
            end
          end else if (timeout_hit) begin
            bus_valid <= 1'b0;
            fault     <= 1'b1;
            if (lat_load) readdata <= '0;
          end else begin
            count <= count + TOW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a driver issues instructions and answers the bus,
// a negedge monitor checks bus requests and retiring results against scoreboard queues.
module tb_load_store_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = '0, writedata = '0;
  logic [31:0] readdata;
  logic        stall, fault, bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT), .TOW(16)) dut (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .writedata(writedata), .readdata(readdata),
    .stall(stall), .fault(fault), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] readdata;
    logic        fault;
    int          stallCycles;
    logic        busUsed;
  } result_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  result_t resultQ[$];
  bus_t    busQ[$];
  int      checks = 0;
  int      failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: bus requests are checked when bus_valid rises and for stability while held;
  // a retiring instruction (access present, stall low) pops and checks a result.
  int      stallCnt;
  logic    busSeen, prevValid;
  bus_t    held;
  result_t r;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt  = 0;
      busSeen   = 1'b0;
      prevValid = 1'b0;
    end else begin
      if ((memread | memwrite) && stall) stallCnt++;
      if (bus_valid && !prevValid) begin
        busSeen = 1'b1;
        if (busQ.size() == 0) checkOutput("unexpected_bus_req", 32'd1, 32'd0);
        else begin
          held = busQ.pop_front();
          checkOutput("bus_addr", bus_addr, held.addr);
          checkOutput("bus_we", 32'(bus_we), 32'(held.we));
          checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(held.wstrb));
          checkOutput("bus_wdata", bus_wdata, held.wdata);
        end
      end else if (bus_valid) begin
        checkOutput("bus_addr_stable", bus_addr, held.addr);
        checkOutput("bus_wstrb_stable", 32'(bus_wstrb), 32'(held.wstrb));
        checkOutput("bus_wdata_stable", bus_wdata, held.wdata);
      end
      if ((memread | memwrite) && !stall) begin
        if (resultQ.size() == 0) checkOutput("unexpected_retire", 32'd1, 32'd0);
        else begin
          r = resultQ.pop_front();
          checkOutput("readdata", readdata, r.readdata);
          checkOutput("fault", 32'(fault), 32'(r.fault));
          checkOutput("stall_cycles", 32'(stallCnt), 32'(r.stallCycles));
          checkOutput("bus_used", 32'(busSeen), 32'(r.busUsed));
        end
        stallCnt = 0;
        busSeen  = 1'b0;
      end else begin
        checkOutput("fault_outside_done", 32'(fault), 32'd0);
      end
      prevValid = bus_valid;
    end
  end

  // Driver: present one instruction, act as bus slave, drop the access after retirement.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int waits, input logic [31:0] rdata, input logic err,
                               input result_t exp, input bus_t expBus);
    int  waited = 0;
    int  n = 0;
    bit  done = 0;
    resultQ.push_back(exp);
    if (exp.busUsed) busQ.push_back(expBus);
    @(posedge clk); #1;
    memread = rd; memwrite = wr; funct3 = f3; addr = a; writedata = wd;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (!stall) begin
        bus_ready = 1'b0; bus_err = 1'b0; done = 1;
      end else if (bus_valid) begin
        if (waited >= waits) begin
          bus_ready = 1'b1; bus_rdata = rdata; bus_err = err;
        end else begin
          bus_ready = 1'b0; waited++;
        end
      end else begin
        bus_ready = 1'b0;
      end
    end
    if (!done) checkOutput("retire_bound", 32'd0, 32'd1);
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0; bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = '0;
  endtask

  localparam bus_t NOBUS = '{32'h0, 1'b0, 4'h0, 32'h0};

  initial begin
    int n;
    #12;
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_bus_valid", 32'(bus_valid), 32'd0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // rd wr f3 addr wd waits rdata err | readdata fault stalls bus | bus addr we wstrb wdata
    applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0,
                  '{32'hDEADBEEF, 1'b0, 2, 1'b1}, '{32'h100, 1'b0, 4'h0, 32'h0});
    applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80123456, 0,
                  '{32'hFFFFFF80, 1'b0, 2, 1'b1}, '{32'h100, 1'b0, 4'h0, 32'h0});
    applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80123456, 0,
                  '{32'h00000080, 1'b0, 2, 1'b1}, '{32'h100, 1'b0, 4'h0, 32'h0});
    applyStimulus(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'h0, 0,
                  '{32'h00000080, 1'b0, 5, 1'b1}, '{32'h200, 1'b1, 4'b1100, 32'hABCDABCD});
    applyStimulus(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 0,
                  '{32'h0, 1'b1, 1, 1'b0}, NOBUS);
    applyStimulus(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80011234, 0,
                  '{32'hFFFF8001, 1'b0, 2, 1'b1}, '{32'h100, 1'b0, 4'h0, 32'h0});
    applyStimulus(0, 1, 3'b100, 32'h200, 32'h11223344, 0, 32'h0, 0,
                  '{32'hFFFF8001, 1'b1, 1, 1'b0}, NOBUS);
    applyStimulus(1, 0, 3'b010, 32'h300, 32'h0, 100, 32'h0, 0,
                  '{32'h0, 1'b1, 5, 1'b1}, '{32'h300, 1'b0, 4'h0, 32'h0});
    applyStimulus(1, 0, 3'b101, 32'h106, 32'h0, 0, 32'h1234ABCD, 0,
                  '{32'h00001234, 1'b0, 2, 1'b1}, '{32'h104, 1'b0, 4'h0, 32'h0});
    applyStimulus(1, 0, 3'b010, 32'h108, 32'h0, 0, 32'hFFFFFFFF, 1,
                  '{32'h0, 1'b1, 2, 1'b1}, '{32'h108, 1'b0, 4'h0, 32'h0});
    applyStimulus(1, 0, 3'b001, 32'h100, 32'h0, 0, 32'h00007FFF, 0,
                  '{32'h00007FFF, 1'b0, 2, 1'b1}, '{32'h100, 1'b0, 4'h0, 32'h0});
    applyStimulus(0, 1, 3'b000, 32'h201, 32'h123456AB, 1, 32'h0, 0,
                  '{32'h00007FFF, 1'b0, 3, 1'b1}, '{32'h200, 1'b1, 4'b0010, 32'hABABABAB});
    applyStimulus(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 32'h0, 0,
                  '{32'h00007FFF, 1'b0, 2, 1'b1}, '{32'h204, 1'b1, 4'b1111, 32'hCAFEF00D});
    applyStimulus(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 0,
                  '{32'h0, 1'b1, 1, 1'b0}, NOBUS);

    // Reset while a load waits in REQ: the request is abandoned and never retires.
    busQ.push_back('{32'h500, 1'b0, 4'h0, 32'h0});
    @(posedge clk); #1;
    memread = 1'b1; funct3 = 3'b010; addr = 32'h500;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_valid && n < 10);
    checkOutput("reset_test_req_seen", 32'(bus_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_bus_valid", 32'(bus_valid), 32'd0);
    checkOutput("midrst_stall", 32'(stall), 32'd0);
    checkOutput("midrst_fault", 32'(fault), 32'd0);
    checkOutput("midrst_readdata", readdata, 32'h0);
    @(posedge clk); #1;
    memread = 1'b0;
    #2 rst_n = 1'b1;

    applyStimulus(1, 0, 3'b010, 32'h400, 32'h0, 0, 32'h13579BDF, 0,
                  '{32'h13579BDF, 1'b0, 2, 1'b1}, '{32'h400, 1'b0, 4'h0, 32'h0});

    repeat (3) @(negedge clk);
    checkOutput("results_drained", 32'(resultQ.size()), 32'd0);
    checkOutput("bus_reqs_drained", 32'(busQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
